// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// master: fetch unit drives request/address; slave: memory drives ready/data.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register, one-entry stall skid and redirect squash.
// Optional FETCH_PERF_EN adds fetch/bubble counters on the IF/ID load.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  fetch_unit_if.master imem,
  output logic         if_id_valid_o,
  output logic [31:0]  if_id_instr_o,
  output logic [31:0]  if_id_pc4_o,
  output logic [5:0]   opcode_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  fetch_count_o,
  output logic [31:0]  bubble_count_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] addr_r, addr_s;
  logic        req_r, req_s;
  logic [31:0] skid_r, skid_s;
  logic        valid_r, valid_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] pc4_r, pc4_s;
  logic        load_s;
  logic        hs_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;

  assign hs_s       = req_r & imem.imem_ready_i;
  assign pc_plus4_s = pc_r + 32'd4;
  assign target_s   = {redirect_pc_i[31:2], 2'b00};

  // Next-state, PC, skid and IF/ID load decisions; redirect overrides everything.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    skid_s  = skid_r;
    valid_s = valid_r;
    instr_s = instr_r;
    pc4_s   = pc4_r;
    load_s  = 1'b0;
    if (redirect_i) begin
      load_s  = 1'b1;
      valid_s = 1'b0;
      instr_s = 32'h0000_0000;
      pc_s    = target_s;
      // An unanswered request must still be drained before using the new PC.
      state_s = (req_r && !imem.imem_ready_i) ? DROP : REQ;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = REQ;
        end
        REQ: begin
          if (hs_s && !stall_i) begin
            load_s  = 1'b1;
            valid_s = 1'b1;
            instr_s = imem.imem_rdata_i;
            pc4_s   = pc_plus4_s;
            pc_s    = pc_plus4_s;
          end else if (hs_s) begin
            skid_s  = imem.imem_rdata_i;
            state_s = HOLD;
          end else if (!stall_i) begin
            load_s  = 1'b1;
            valid_s = 1'b0;
            instr_s = 32'h0000_0000;
          end else begin
            state_s = REQ;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            load_s  = 1'b1;
            valid_s = 1'b1;
            instr_s = skid_r;
            pc4_s   = pc_plus4_s;
            pc_s    = pc_plus4_s;
            state_s = REQ;
          end else begin
            state_s = HOLD;
          end
        end
        DROP: begin
          state_s = imem.imem_ready_i ? REQ : DROP;
          if (!stall_i) begin
            load_s  = 1'b1;
            valid_s = 1'b0;
            instr_s = 32'h0000_0000;
          end else begin
            load_s  = 1'b0;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
    addr_s = (state_s == DROP) ? addr_r : pc_s;
    req_s  = (state_s == REQ) || (state_s == DROP);
  end

  // State, PC, request and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
      req_r   <= 1'b0;
      skid_r  <= 32'h0000_0000;
      valid_r <= 1'b0;
      instr_r <= 32'h0000_0000;
      pc4_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      addr_r  <= addr_s;
      req_r   <= req_s;
      skid_r  <= skid_s;
      valid_r <= valid_s;
      instr_r <= instr_s;
      pc4_r   <= pc4_s;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] bubble_cnt_r;

  // Count IF/ID loads split by whether a real instruction was loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_r  <= 32'd0;
      bubble_cnt_r <= 32'd0;
    end else if (load_s && valid_s) begin
      fetch_cnt_r  <= fetch_cnt_r + 32'd1;
    end else if (load_s) begin
      bubble_cnt_r <= bubble_cnt_r + 32'd1;
    end
  end

  assign fetch_count_o  = fetch_cnt_r;
  assign bubble_count_o = bubble_cnt_r;
`endif

  assign imem.imem_req_o  = req_r;
  assign imem.imem_addr_o = addr_r;
  assign if_id_valid_o    = valid_r;
  assign if_id_instr_o    = instr_r;
  assign if_id_pc4_o      = pc4_r;
  assign opcode_o         = instr_r[31:26];

endmodule
